mmio_peripheral: RTL and testbench

MMIO_PERIPHERAL -- requirements
Module: mmio_peripheral

---
 rtl/mmio_pkg.sv | 46 ++++
 rtl/mmio_peripheral_if.sv | 19 +
 rtl/mmio_peripheral_hex7seg.sv | 32 +++
 rtl/mmio_peripheral.sv | 155 +++++++++++++++
 tb/tb_mmio_peripheral.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// mmio_peripheral shared definitions:
// register addresses, TCON bits, decoder.
package mmio_pkg;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

  localparam int TCON_RUN = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_ST  = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SWITCH,
    SEL_DIGI,
    SEL_SYSTICK
  } reg_sel_e;

  function automatic reg_sel_e decode(
    input logic [31:0] a
  );
    reg_sel_e s;
    s = SEL_NONE;
    unique case (1'b1)
      (a == ADDR_TH):      s = SEL_TH;
      (a == ADDR_TL):      s = SEL_TL;
      (a == ADDR_TCON):    s = SEL_TCON;
      (a == ADDR_LED):     s = SEL_LED;
      (a == ADDR_SWITCH):  s = SEL_SWITCH;
      (a == ADDR_DIGI):    s = SEL_DIGI;
      (a == ADDR_SYSTICK): s = SEL_SYSTICK;
      default:             s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_peripheral_if.sv
// mmio_peripheral bus: read/write strobes,
// byte address, write data, comb read data.
interface mmio_peripheral_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mmio_peripheral_hex7seg.sv
// Hex nibble to 7-segment decoder,
// active-low, bit0 = segment a.
module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // gfedcba patterns, 0 = lit
  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/mmio_peripheral.sv
// MMIO timer/LED/switch/7-seg peripheral.
// Define PERIPH_SYSTICK_EN for SYSTICK counter.
module mmio_peripheral #(
  parameter int LED_W      = 8,
  parameter int SW_W       = 8,
  parameter int NUM_DIGITS = 4,
  parameter int TIMER_W    = 32,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  sysclk,
  input  logic                  reset,
  mmio_peripheral_if.slave      bus,
  input  logic [SW_W-1:0]       switch,
  output logic [LED_W-1:0]      led,
  output logic [NUM_DIGITS-1:0] digi_an,
  output logic [6:0]            digi_seg,
  output logic                  irq
);
  import mmio_pkg::*;

  localparam int DW    = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TIMER_W-1:0] th, tl;
  logic               run, ie, st;
  logic [DW-1:0]      digi;
  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic [SW_W-1:0]    sw_s1, sw_s2;
  logic [3:0]         nib;
  reg_sel_e           wsel, rsel;
  logic               tl_wr, tcon_wr;
  logic               tl_max, reload;

  assign wsel    = bus.wr ? decode(bus.addr)
                          : SEL_NONE;
  assign rsel    = decode(bus.addr);
  assign tl_wr   = (wsel == SEL_TL);
  assign tcon_wr = (wsel == SEL_TCON);
  assign tl_max  = &tl;
  // a software TL write preempts the reload
  assign reload  = run & tl_max & ~tl_wr;
  assign irq     = st;

  // timer: TH/TL/TCON, reload and status
  always_ff @(posedge sysclk) begin
    if (reset) begin
      th  <= '0;
      tl  <= '0;
      run <= 1'b0;
      ie  <= 1'b0;
      st  <= 1'b0;
    end else begin
      if (wsel == SEL_TH)
        th <= bus.wdata[TIMER_W-1:0];
      if (tl_wr)
        tl <= bus.wdata[TIMER_W-1:0];
      else if (run)
        tl <= tl_max ? th : tl + TIMER_W'(1);
      if (tcon_wr) begin
        run <= bus.wdata[TCON_RUN];
        ie  <= bus.wdata[TCON_IE];
      end
      if (reload && ie)
        st <= 1'b1;
      else if (tcon_wr && !bus.wdata[TCON_ST])
        st <= 1'b0;
    end
  end

  // LED and DIGI registers
  always_ff @(posedge sysclk) begin
    if (reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wsel == SEL_LED)
        led <= bus.wdata[LED_W-1:0];
      if (wsel == SEL_DIGI)
        digi <= bus.wdata[DW-1:0];
    end
  end

  // 2-flop switch synchroniser
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
    end
  end

  // digit scan: slot counter and index
  always_ff @(posedge sysclk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt ==
                 CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (idx == IDX_W'(NUM_DIGITS - 1))
        idx <= '0;
      else
        idx <= idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick;

  // free-running cycle counter
  always_ff @(posedge sysclk) begin
    if (reset)
      systick <= '0;
    else
      systick <= systick + 32'd1;
  end
`else
  logic [31:0] systick;
  assign systick = '0;
`endif

  assign digi_an =
    ~(NUM_DIGITS'(1) << idx);
  assign nib = 4'(digi >> {idx, 2'b00});

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (digi_seg)
  );

  // combinational read mux, zero-extended
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      case (rsel)
        SEL_TH:      bus.rdata = 32'(th);
        SEL_TL:      bus.rdata = 32'(tl);
        SEL_TCON:    bus.rdata = {29'd0, st, ie, run};
        SEL_LED:     bus.rdata = 32'(led);
        SEL_SWITCH:  bus.rdata = 32'(sw_s2);
        SEL_DIGI:    bus.rdata = 32'(digi);
        SEL_SYSTICK: bus.rdata = systick;
        default:     bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral
// (honours PERIPH_SYSTICK_EN when defined).
module tb_mmio_peripheral;
  import mmio_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [7:0] led;
  logic [3:0] an;
  logic [6:0] seg;
  logic       irq;

  always #5 clk = ~clk;

  mmio_peripheral_if bus();

  mmio_peripheral #(
    .LED_W      (8),
    .SW_W       (8),
    .NUM_DIGITS (4),
    .TIMER_W    (32),
    .SCAN_DIV   (4)
  ) dut (
    .sysclk   (clk),
    .reset    (rst),
    .bus      (bus),
    .switch   (sw),
    .led      (led),
    .digi_an  (an),
    .digi_seg (seg),
    .irq      (irq)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e, got;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

`ifdef PERIPH_SYSTICK_EN
  localparam logic [31:0] TICK1 = 32'd1;
`else
  localparam logic [31:0] TICK1 = 32'd0;
`endif

  logic [31:0] addrs [7] = '{
    ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED,
    ADDR_SWITCH, ADDR_DIGI, ADDR_SYSTICK
  };

  // called at a negedge; write lands on next posedge
  task automatic wr_reg(
    input logic [31:0] a,
    input logic [31:0] d
  );
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr    = 1'b0;
  endtask

  task automatic rd_reg(
    input  logic [31:0] a,
    output logic [31:0] v
  );
    bus.rd   = 1'b1;
    bus.addr = a;
    #1;
    v = bus.rdata;
    bus.rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(32'd0);
      rd_reg(addrs[i], got);
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_reg%0d got %h want %h",
                 i, got, e);
      end
      n_cmp++;
      @(negedge clk);
    end
    exp_q.push_back({19'd0, irq, led, an});
    exp_q.push_back({20'd0, 1'b0, 8'h00, 4'hE});
    e = exp_q.pop_back();
    got = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL reset_out got %h want %h",
               got, e);
    end
    n_cmp++;
    exp_q.push_back({25'd0, 7'h40});
    e = exp_q.pop_front();
    if ({25'd0, seg} !== e) begin
      n_err++;
      $display("FAIL reset_seg got %h want %h",
               seg, e);
    end
    n_cmp++;
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(TICK1);
    rd_reg(ADDR_SYSTICK, got);
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL systick_inc got %h want %h",
               got, e);
    end
    n_cmp++;
  endtask

  task automatic test_timer_reload();
    wr_reg(ADDR_TH, 32'hFFFF_FFFC);
    wr_reg(ADDR_TL, 32'hFFFF_FFFE);
    wr_reg(ADDR_TCON, 32'd3);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'd1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      rd_reg(ADDR_TL, got);
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL reload_tl%0d got %h want %h",
                 c, got, e);
      end
      n_cmp++;
      e = exp_q.pop_front();
      if ({31'd0, irq} !== e) begin
        n_err++;
        $display("FAIL reload_irq%0d got %b want %0d",
                 c, irq, e);
      end
      n_cmp++;
    end
  endtask

  task automatic test_irq_clear();
    repeat (3) @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFF);
    rd_reg(ADDR_TL, got);
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL pre_reload_tl got %h want %h",
               got, e);
    end
    n_cmp++;
    wr_reg(ADDR_TCON, 32'd3);
    exp_q.push_back(32'd7);
    rd_reg(ADDR_TCON, got);
    e = exp_q.pop_front();
    if (got !== e || irq !== 1'b1) begin
      n_err++;
      $display("FAIL set_wins tcon %h irq %b want %h/1",
               got, irq, e);
    end
    n_cmp++;
    wr_reg(ADDR_TCON, 32'd3);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'hFFFF_FFFD);
    rd_reg(ADDR_TCON, got);
    e = exp_q.pop_front();
    if (got !== e || irq !== 1'b0) begin
      n_err++;
      $display("FAIL sw_clear tcon %h irq %b want %h/0",
               got, irq, e);
    end
    n_cmp++;
    rd_reg(ADDR_TL, got);
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL clear_tl got %h want %h",
               got, e);
    end
    n_cmp++;
  endtask

  task automatic test_irq_disabled();
    logic [31:0] seq [8];
    seq = '{32'hFFFF_FFFD, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'hFFFF_FFFE};
    wr_reg(ADDR_TCON, 32'd0);
    wr_reg(ADDR_TH, 32'hFFFF_FFFE);
    wr_reg(ADDR_TL, 32'hFFFF_FFFD);
    wr_reg(ADDR_TCON, 32'd1);
    for (int c = 0; c < 8; c++)
      exp_q.push_back(seq[c]);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      rd_reg(ADDR_TL, got);
      e = exp_q.pop_front();
      if (got !== e || irq !== 1'b0) begin
        n_err++;
        $display("FAIL noie_%0d tl %h irq %b want %h/0",
                 c, got, irq, e);
      end
      n_cmp++;
    end
  endtask

  task automatic test_tl_write_priority();
    wr_reg(ADDR_TCON, 32'd0);
    wr_reg(ADDR_TL, 32'hFFFF_FFFE);
    wr_reg(ADDR_TH, 32'h0000_0100);
    wr_reg(ADDR_TCON, 32'd3);
    @(negedge clk);
    wr_reg(ADDR_TL, 32'd5);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd6);
    rd_reg(ADDR_TL, got);
    e = exp_q.pop_front();
    if (got !== e || irq !== 1'b0) begin
      n_err++;
      $display("FAIL tlwr_wins tl %h irq %b want %h/0",
               got, irq, e);
    end
    n_cmp++;
    @(negedge clk);
    rd_reg(ADDR_TL, got);
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL tlwr_next got %h want %h",
               got, e);
    end
    n_cmp++;
  endtask

  task automatic test_digits();
    logic [3:0] nibs [4];
    int slot;
    nibs = '{4'h4, 4'h3, 4'h2, 4'h1};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_reg(ADDR_DIGI, 32'h0000_1234);
    for (int i = 0; i < 16; i++) begin
      slot = ((i + 1) / 4) % 4;
      exp_q.push_back({21'd0,
                       ~(4'b0001 << slot),
                       seg_tab[nibs[slot]]});
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      if ({21'd0, an, seg} !== e) begin
        n_err++;
        $display("FAIL scan_%0d an %b seg %h want %h",
                 i, an, seg, e);
      end
      n_cmp++;
    end
    for (int v = 0; v < 16; v++) begin
      wr_reg(ADDR_DIGI, {16'd0, {4{4'(v)}}});
      exp_q.push_back({25'd0, seg_tab[v]});
      e = exp_q.pop_front();
      if ({25'd0, seg} !== e) begin
        n_err++;
        $display("FAIL hex_%0d seg %h want %h",
                 v, seg, e);
      end
      n_cmp++;
    end
  endtask

  task automatic test_switch_led();
    sw = 8'hA5;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hA5);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      rd_reg(ADDR_SWITCH, got);
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL sync_%0d got %h want %h",
                 c, got, e);
      end
      n_cmp++;
    end
    @(negedge clk);
    wr_reg(ADDR_SWITCH, 32'h0);
    wr_reg(32'h4000_001C, 32'h55);
    wr_reg(ADDR_LED, 32'h1FF);
    exp_q.push_back(32'hA5);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'd0);
    rd_reg(ADDR_SWITCH, got);
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL ro_write got %h want %h",
               got, e);
    end
    n_cmp++;
    rd_reg(32'h4000_001C, got);
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL unmapped got %h want %h",
               got, e);
    end
    n_cmp++;
    e = exp_q.pop_front();
    if ({24'd0, led} !== e) begin
      n_err++;
      $display("FAIL led_out got %h want %h",
               led, e);
    end
    n_cmp++;
    rd_reg(ADDR_LED, got);
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL led_read got %h want %h",
               got, e);
    end
    n_cmp++;
    bus.rd   = 1'b0;
    bus.addr = ADDR_LED;
    #1;
    got = bus.rdata;
    e = exp_q.pop_front();
    if (got !== e) begin
      n_err++;
      $display("FAIL rd_low got %h want %h",
               got, e);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wr_reg(ADDR_TH, 32'hFFFF_FFF0);
    wr_reg(ADDR_TL, 32'hFFFF_FFFE);
    wr_reg(ADDR_TCON, 32'd3);
    repeat (2) @(negedge clk);
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    if ({31'd0, irq} !== e) begin
      n_err++;
      $display("FAIL mid_irq_pre got %b want %0d",
               irq, e);
    end
    n_cmp++;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(32'd0);
      rd_reg(addrs[i], got);
      e = exp_q.pop_front();
      if (got !== e || irq !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reg%0d %h irq %b want %h/0",
                 i, got, irq, e);
      end
      n_cmp++;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'd0);
    rd_reg(ADDR_TL, got);
    e = exp_q.pop_front();
    if (got !== e || irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_after tl %h irq %b want %h/0",
               got, irq, e);
    end
    n_cmp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    sw        = 8'h00;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    @(negedge clk);
    test_reset();
    test_timer_reload();
    test_irq_clear();
    test_irq_disabled();
    test_tl_write_priority();
    test_digits();
    test_switch_led();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
